// File: rtl/gpio_ctrl_pkg.sv
// Shared register map and bus helpers for the gpio_ctrl peripheral.
// Optional input glitch filter is enabled with GPIO_FILTER_EN.
package gpio_ctrl_pkg;

   localparam logic [15:0] GPIO_OE_OFS      = 16'h0000;
   localparam logic [15:0] GPIO_DOUT_OFS    = 16'h0004;
   localparam logic [15:0] GPIO_DIN_OFS     = 16'h0008;
   localparam logic [15:0] GPIO_IRQ_EN_OFS  = 16'h000C;
   localparam logic [15:0] GPIO_RISE_EN_OFS = 16'h0010;
   localparam logic [15:0] GPIO_FALL_EN_OFS = 16'h0014;
   localparam logic [15:0] GPIO_STATUS_OFS  = 16'h0018;

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      logic [31:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Per-line input conditioning: 2-flop synchroniser, plus a stable-count
// glitch filter when GPIO_FILTER_EN is defined.
module gpio_in_sync
   import gpio_ctrl_pkg::*;
#(
   parameter int unsigned FILTER_CNT = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pin_i,
   output logic din_o
);

   logic sync1_d, sync1_q;
   logic sync2_d, sync2_q;

   always_comb begin
      sync1_d = pin_i;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef GPIO_FILTER_EN
   localparam int unsigned CW = $clog2(FILTER_CNT + 1);

   logic [CW-1:0] cnt_d, cnt_q;
   logic          din_d, din_q;

   // Count consecutive cycles of disagreement; adopt the new level on the last one.
   always_comb begin
      cnt_d = '0;
      din_d = din_q;
      if (sync2_q != din_q) begin
         if (cnt_q == CW'(FILTER_CNT - 1)) begin
            din_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         din_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         din_q <= din_d;
      end
   end

   assign din_o = din_q;
`else
   assign din_o = sync2_q;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// OBI register-mapped GPIO controller with edge-detect interrupts.
// Define GPIO_FILTER_EN to insert the per-line input glitch filter.
module gpio_ctrl
   import gpio_ctrl_pkg::*;
#(
   parameter int unsigned GPIO_NUM   = 16,
   parameter int unsigned FILTER_CNT = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [3:0]          be_i,
   input  logic [31:0]         addr_i,
   input  logic [31:0]         data_i,
   output logic                gnt_o,
   output logic                rvalid_o,
   output logic [31:0]         data_o,
   output logic [GPIO_NUM-1:0] gpio_oe_o,
   output logic [GPIO_NUM-1:0] gpio_val_o,
   input  logic [GPIO_NUM-1:0] gpio_val_i,
   output logic                irq_o
);

   logic [GPIO_NUM-1:0] din;

   for (genvar g = 0; g < GPIO_NUM; g++) begin : g_sync
      gpio_in_sync #(.FILTER_CNT(FILTER_CNT)) u_sync (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .pin_i  (gpio_val_i[g]),
         .din_o  (din[g])
      );
   end

   logic [GPIO_NUM-1:0] oe_d, oe_q, dout_d, dout_q, irq_en_d, irq_en_q;
   logic [GPIO_NUM-1:0] rise_en_d, rise_en_q, fall_en_d, fall_en_q;
   logic [GPIO_NUM-1:0] status_d, status_q, prev_d, prev_q;
   logic [1:0]          arm_d, arm_q;
   logic                rvalid_d, rvalid_q, irq_d, irq_q;
   logic [31:0]         rdata_d, rdata_q;

   logic [15:0]         ofs;
   logic [31:0]         be_mask, rd;
   logic [GPIO_NUM-1:0] wmask, wdata, clr, evt;
   logic                wr, unused_bits;

   always_comb begin
      ofs         = addr_i[15:0];
      be_mask     = be_to_mask(be_i);
      wmask       = be_mask[GPIO_NUM-1:0];
      wdata       = data_i[GPIO_NUM-1:0];
      wr          = req_i & we_i;
      unused_bits = ^{addr_i[31:16], data_i, be_mask};

      oe_d      = oe_q;
      dout_d    = dout_q;
      irq_en_d  = irq_en_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      if (wr) begin
         case (ofs)
            GPIO_OE_OFS:      oe_d      = (oe_q      & ~wmask) | (wdata & wmask);
            GPIO_DOUT_OFS:    dout_d    = (dout_q    & ~wmask) | (wdata & wmask);
            GPIO_IRQ_EN_OFS:  irq_en_d  = (irq_en_q  & ~wmask) | (wdata & wmask);
            GPIO_RISE_EN_OFS: rise_en_d = (rise_en_q & ~wmask) | (wdata & wmask);
            GPIO_FALL_EN_OFS: fall_en_d = (fall_en_q & ~wmask) | (wdata & wmask);
            default: ;
         endcase
      end

      // Edges stay masked until the synchroniser has flushed its reset state.
      evt      = (din & ~prev_q & rise_en_q) | (~din & prev_q & fall_en_q);
      evt      = (arm_q == 2'd3) ? evt : '0;
      clr      = (wr && ofs == GPIO_STATUS_OFS) ? (wdata & wmask) : '0;
      status_d = (status_q & ~clr) | evt;
      prev_d   = din;
      arm_d    = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;

      rd = '0;
      case (ofs)
         GPIO_OE_OFS:      rd[GPIO_NUM-1:0] = oe_q;
         GPIO_DOUT_OFS:    rd[GPIO_NUM-1:0] = dout_q;
         GPIO_DIN_OFS:     rd[GPIO_NUM-1:0] = din;
         GPIO_IRQ_EN_OFS:  rd[GPIO_NUM-1:0] = irq_en_q;
         GPIO_RISE_EN_OFS: rd[GPIO_NUM-1:0] = rise_en_q;
         GPIO_FALL_EN_OFS: rd[GPIO_NUM-1:0] = fall_en_q;
         GPIO_STATUS_OFS:  rd[GPIO_NUM-1:0] = status_q;
         default: ;
      endcase
      rdata_d  = (req_i && !we_i) ? rd : rdata_q;
      rvalid_d = req_i;
      irq_d    = |(status_q & irq_en_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         oe_q      <= '0;
         dout_q    <= '0;
         irq_en_q  <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         prev_q    <= '0;
         arm_q     <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         oe_q      <= oe_d;
         dout_q    <= dout_d;
         irq_en_q  <= irq_en_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         prev_q    <= prev_d;
         arm_q     <= arm_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
      end
   end

   assign gnt_o      = req_i;
   assign rvalid_o   = rvalid_q;
   assign data_o     = rdata_q;
   assign gpio_oe_o  = oe_q;
   assign gpio_val_o = dout_q;
   assign irq_o      = irq_q;

endmodule
